// File: rtl/fetch_request_unit_if.sv
// Fetch/decode/cache signal bundle between fetch_request_unit, control_unit and the I/D caches.
// The master side belongs to fetch_request_unit. The slave side belongs to the caches and control_unit.
interface fetch_request_unit_if;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] imemaddr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [1:0]  PCSel;
    logic        branch;
    logic        branchSel;
    logic        zero;
    logic [31:0] jr_addr;
    logic        dREN;
    logic        dWEN;
    logic        dhit;
    logic        dmemREN;
    logic        dmemWEN;
    logic        halt;
    logic        halted;
    logic        commit;

    modport master (
        input  ihit, imemload, PCSel, branch, branchSel, zero, jr_addr,
               dREN, dWEN, dhit, halt,
        output iREN, imemaddr, instr, pc, npc, dmemREN, dmemWEN, halted, commit
    );

    modport slave (
        output ihit, imemload, PCSel, branch, branchSel, zero, jr_addr,
               dREN, dWEN, dhit, halt,
        input  iREN, imemaddr, instr, pc, npc, dmemREN, dmemWEN, halted, commit
    );
endinterface

// File: rtl/fetch_request_unit.sv
// Multicycle MIPS fetch sequencer: owns PC/IR, issues I/D cache requests, computes next PC.
// Latency: ihit cycle + EXEC cycle (+ MEM cycles up to dhit). Cache requests are held until the hit arrives. Commit pulses on retire.
module fetch_request_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic                  CLK,
    input  logic                  nRST,
    fetch_request_unit_if.master  bus
);
    typedef enum logic [2:0] {START, FETCH, EXEC, MEM, HALT} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;

    logic [31:0] w_npc;
    logic [31:0] w_br_off;
    logic        w_taken;
    logic [31:0] w_next_pc;
    logic        w_mem_req;

    assign w_npc     = r_pc + 32'd4;
    assign w_br_off  = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
    assign w_taken   = bus.branch & (bus.zero ^ bus.branchSel);
    assign w_mem_req = bus.dREN | bus.dWEN;

    always_comb begin
        w_next_pc = w_npc;
        case (bus.PCSel)
            2'b00:   w_next_pc = {w_npc[31:28], r_ir[25:0], 2'b00};
            2'b01:   w_next_pc = w_taken ? (w_npc + w_br_off) : w_npc;
            2'b10:   w_next_pc = bus.jr_addr;
            default: w_next_pc = w_npc;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= START;
            r_pc    <= PC_INIT;
            r_ir    <= 32'h0;
        end else begin
            case (r_state)
                START: r_state <= FETCH;
                FETCH: begin
                    if (bus.ihit) begin
                        r_ir    <= bus.imemload;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (bus.halt) begin
                        r_state <= HALT;
                    end else if (w_mem_req) begin
                        r_state <= MEM;
                    end else begin
                        r_pc    <= w_next_pc;
                        r_state <= FETCH;
                    end
                end
                MEM: begin
                    // ihit is deliberately ignored here even if it coincides with dhit.
                    if (bus.dhit) begin
                        r_pc    <= w_next_pc;
                        r_state <= FETCH;
                    end
                end
                HALT:    r_state <= HALT;
                default: r_state <= START;
            endcase
        end
    end

    assign bus.iREN     = (r_state == FETCH);
    assign bus.imemaddr = r_pc;
    assign bus.pc       = r_pc;
    assign bus.npc      = w_npc;
    assign bus.instr    = r_ir;
    assign bus.dmemREN  = (r_state == MEM) & bus.dREN;
    assign bus.dmemWEN  = (r_state == MEM) & bus.dWEN;
    assign bus.halted   = (r_state == HALT);
    assign bus.commit   = ((r_state == EXEC) & ~bus.halt & ~w_mem_req)
                        | ((r_state == MEM) & bus.dhit);
endmodule

// File: tb/tb_fetch_request_unit.sv
// Self-checking bench for fetch_request_unit: expected PCs are queued per instruction and popped at retire.
module tb_fetch_request_unit;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    fetch_request_unit_if bus();
    fetch_request_unit #(.PC_INIT(32'h0000_0000)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_commits = 0;
    int          exp_commits = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_pc = 32'h0;

    always @(posedge CLK) if (bus.commit === 1'b1) n_commits++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        bus.ihit = 0; bus.imemload = 0; bus.PCSel = 2'b11; bus.branch = 0;
        bus.branchSel = 0; bus.zero = 0; bus.jr_addr = 0; bus.dREN = 0;
        bus.dWEN = 0; bus.dhit = 0; bus.halt = 0;
    endtask

    // Returns 1 at a negedge+1 with iREN high, 0 if the budget ran out.
    task automatic wait_fetch(input string name, output bit ok);
        int cnt = 0;
        @(negedge CLK); #1;
        while (bus.iREN !== 1'b1 && cnt < 20) begin
            @(negedge CLK); #1;
            cnt++;
        end
        ok = (bus.iREN === 1'b1);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s wait_fetch: iREN=%b required 1 within 20 cycles", name, bus.iREN);
        end
    endtask

    task automatic run_instr(input string name, input logic [31:0] ir, input logic [1:0] sel,
                             input logic br, input logic bsel, input logic z,
                             input logic [31:0] jr, input logic dren, input logic dwen,
                             input int mem_cycles, input logic [31:0] exp_pc);
        bit ok;
        logic [31:0] want;
        exp_q.push_back(exp_pc);
        wait_fetch(name, ok);
        if (!ok) begin
            void'(exp_q.pop_front());
            return;
        end
        n_tests++;
        if (bus.imemaddr !== m_pc) begin
            n_fail++;
            $display("FAIL %s imemaddr: got %h required %h", name, bus.imemaddr, m_pc);
        end
        bus.ihit = 1; bus.imemload = ir; bus.PCSel = sel; bus.branch = br;
        bus.branchSel = bsel; bus.zero = z; bus.jr_addr = jr; bus.dREN = dren; bus.dWEN = dwen;
        @(negedge CLK); bus.ihit = 0; bus.imemload = 32'hDEAD_BEEF; #1;
        n_tests++;
        if (bus.instr !== ir) begin
            n_fail++;
            $display("FAIL %s IR: got %h required %h", name, bus.instr, ir);
        end
        n_tests++;
        if ({bus.iREN, bus.dmemREN, bus.dmemWEN} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s exec_requests: got %b required 000", name, {bus.iREN, bus.dmemREN, bus.dmemWEN});
        end
        n_tests++;
        if (bus.commit !== (mem_cycles == 0)) begin
            n_fail++;
            $display("FAIL %s exec_commit: got %b required %b", name, bus.commit, mem_cycles == 0);
        end
        for (int k = 0; k < mem_cycles; k++) begin
            @(negedge CLK);
            bus.ihit = 1;
            bus.dhit = (k == mem_cycles - 1);
            #1;
            n_tests++;
            if ({bus.iREN, bus.dmemREN, bus.dmemWEN} !== {1'b0, dren, dwen}) begin
                n_fail++;
                $display("FAIL %s mem_requests[%0d]: got %b required %b", name, k,
                         {bus.iREN, bus.dmemREN, bus.dmemWEN}, {1'b0, dren, dwen});
            end
            n_tests++;
            if (bus.commit !== (k == mem_cycles - 1)) begin
                n_fail++;
                $display("FAIL %s mem_commit[%0d]: got %b required %b", name, k, bus.commit, k == mem_cycles - 1);
            end
        end
        @(posedge CLK); #1;
        drive_idle();
        exp_commits++;
        want = exp_q.pop_front();
        n_tests++;
        if (bus.pc !== want) begin
            n_fail++;
            $display("FAIL %s next_pc: got %h required %h", name, bus.pc, want);
        end
        m_pc = want;
    endtask

    task automatic test_reset();
        drive_idle();
        nRST = 0;
        #12;
        n_tests++;
        if ({bus.iREN, bus.dmemREN, bus.dmemWEN, bus.halted, bus.commit} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {bus.iREN, bus.dmemREN, bus.dmemWEN, bus.halted, bus.commit});
        end
        n_tests++;
        if ({bus.instr, bus.pc, bus.imemaddr} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_regs: instr=%h pc=%h imemaddr=%h required all 0", bus.instr, bus.pc, bus.imemaddr);
        end
        @(negedge CLK); nRST = 1; #1;
        n_tests++;
        if (bus.iREN !== 1'b0) begin
            n_fail++;
            $display("FAIL start_state: iREN=%b required 0", bus.iREN);
        end
        m_pc = 32'h0;
    endtask

    task automatic test_sequential();
        run_instr("addi0", 32'h2001_0005, 2'b11, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0004);
        run_instr("addi4", 32'h2002_0007, 2'b11, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0008);
    endtask

    task automatic test_branches();
        run_instr("beq_taken", 32'h1000_FFFF, 2'b01, 1, 0, 1, 0, 0, 0, 0, 32'h0000_0008);
        run_instr("bne_not_taken", 32'h1400_FFFF, 2'b01, 1, 1, 1, 0, 0, 0, 0, 32'h0000_000C);
        run_instr("bne_taken", 32'h1400_0004, 2'b01, 1, 1, 0, 0, 0, 0, 0, 32'h0000_0020);
    endtask

    task automatic test_jumps();
        run_instr("jr_hi", 32'h03E0_0008, 2'b10, 0, 0, 0, 32'h1000_0000, 0, 0, 0, 32'h1000_0000);
        run_instr("j", 32'h0800_0010, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h1000_0040);
        run_instr("jr", 32'h03E0_0008, 2'b10, 0, 0, 0, 32'h0000_0100, 0, 0, 0, 32'h0000_0100);
    endtask

    task automatic test_mem();
        run_instr("lw_wait3", 32'h8C22_0000, 2'b11, 0, 0, 0, 0, 1, 0, 3, 32'h0000_0104);
        run_instr("sw_wait1", 32'hAC22_0004, 2'b11, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0108);
        run_instr("pc_wrap_jr", 32'h03E0_0008, 2'b10, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC);
        run_instr("pc_wrap", 32'h2001_0001, 2'b11, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000);
    endtask

    task automatic test_reset_in_mem();
        bit ok;
        int commits_before;
        run_instr("pre_jr", 32'h03E0_0008, 2'b10, 0, 0, 0, 32'h0000_0200, 0, 0, 0, 32'h0000_0200);
        wait_fetch("reset_in_mem", ok);
        if (!ok) return;
        bus.ihit = 1; bus.imemload = 32'hAC22_0000; bus.dWEN = 1;
        @(negedge CLK); bus.ihit = 0;
        @(negedge CLK); #1;
        commits_before = n_commits;
        n_tests++;
        if (bus.dmemWEN !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_mem pre: dmemWEN=%b required 1", bus.dmemWEN);
        end
        #1 nRST = 0; #1;
        n_tests++;
        if ({bus.dmemWEN, bus.commit, bus.iREN} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_in_mem drop: {dmemWEN,commit,iREN}=%b required 000", {bus.dmemWEN, bus.commit, bus.iREN});
        end
        n_tests++;
        if (bus.pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_in_mem pc: got %h required 00000000", bus.pc);
        end
        @(posedge CLK); #1;
        drive_idle();
        @(negedge CLK); nRST = 1;
        n_tests++;
        if (n_commits !== commits_before) begin
            n_fail++;
            $display("FAIL reset_in_mem commit: commits=%0d required %0d", n_commits, commits_before);
        end
        m_pc = 32'h0;
        run_instr("after_reset", 32'h2001_0003, 2'b11, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0004);
    endtask

    task automatic test_halt();
        bit ok;
        wait_fetch("halt", ok);
        if (!ok) return;
        bus.ihit = 1; bus.imemload = 32'h0000_000C; bus.halt = 1; bus.PCSel = 2'b10;
        bus.jr_addr = 32'h0000_0800;
        @(negedge CLK); bus.ihit = 0; #1;
        n_tests++;
        if (bus.commit !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_exec_commit: got %b required 0", bus.commit);
        end
        @(posedge CLK); #1;
        bus.halt = 0; bus.ihit = 1; bus.dREN = 1; bus.dWEN = 1; bus.dhit = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK); #1;
            n_tests++;
            if ({bus.halted, bus.iREN, bus.dmemREN, bus.dmemWEN, bus.commit} !== 5'b10000) begin
                n_fail++;
                $display("FAIL halt_outputs[%0d]: got %b required 10000", k,
                         {bus.halted, bus.iREN, bus.dmemREN, bus.dmemWEN, bus.commit});
            end
            n_tests++;
            if (bus.pc !== m_pc) begin
                n_fail++;
                $display("FAIL halt_pc[%0d]: got %h required %h", k, bus.pc, m_pc);
            end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branches();
        test_jumps();
        test_mem();
        test_reset_in_mem();
        test_halt();
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        n_tests++;
        if (n_commits !== exp_commits) begin
            n_fail++;
            $display("FAIL commit_count: got %0d required %0d", n_commits, exp_commits);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
